// File: rtl/trap_pkg.sv
// trap_pkg: shared constants and types for the trap controller.
//   - CSR addresses touched by trap entry/exit
//   - instruction encodings decoded in ID (ecall/ebreak/mret)
//   - synchronous exception cause codes
//   - FSM state enumeration
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int unsigned CAUSE_ECALL_M    = 11;
  localparam int unsigned CAUSE_BREAKPOINT = 3;

  // mstatus bit positions used by the entry/exit sequences
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WR_MEPC     = 3'd1,
    WR_MCAUSE   = 3'd2,
    WR_MSTATUS  = 3'd3,
    MRET_STATUS = 3'd4,
    JUMP        = 3'd5
  } trap_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: masked fixed-priority encoder. Index 0 has highest priority.
// Ports:
//   req_i   [NUM_IRQ-1:0]  raw request lines
//   mask_i  [NUM_IRQ-1:0]  per-line enables
//   valid_o                at least one enabled request
//   idx_o   [IDX_W-1:0]    lowest enabled requesting index (0 when !valid_o)
module irq_prio_enc
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_IRQ-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_mask
      assign hit[gi] = req_i[gi] & mask_i[gi];
    end
  endgenerate

  assign valid_o = |hit;

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (hit[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: arbitrates interrupts and ecall/ebreak/mret seen in ID, sequences
// the CSR writes for trap entry/exit, stalls the pipeline while doing so and
// finishes with a one-cycle redirect.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   irq[NUM_IRQ]             level interrupt requests
//   inst, inst_addr          instruction and PC currently in ID
//   jump_flag_ex/addr_ex     EX redirect this cycle (used as irq return PC)
//   csr_mstatus/mie/mtvec/mepc  current CSR values
//   csr_we/wa/wd             CSR write port (registered)
//   stall_flag               hold IF/ID, squash ID->EX (combinational)
//   jump_flag/jump_addr      one-cycle redirect (registered)
//   trap_active              FSM not in IDLE
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int NUM_IRQ        = 4,
  parameter int XLEN           = 32,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter bit VECTORED_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        inst,
  input  logic [XLEN-1:0]    inst_addr,
  input  logic               jump_flag_ex,
  input  logic [XLEN-1:0]    jump_addr_ex,
  input  logic [XLEN-1:0]    csr_mstatus,
  input  logic [XLEN-1:0]    csr_mie,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_mepc,
  output logic               csr_we,
  output logic [11:0]        csr_wa,
  output logic [XLEN-1:0]    csr_wd,
  output logic               stall_flag,
  output logic               jump_flag,
  output logic [XLEN-1:0]    jump_addr,
  output logic               trap_active
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e state_q, state_d;

  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] ret_pc_q, ret_pc_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            csr_we_q, csr_we_d;
  logic [11:0]     csr_wa_q, csr_wa_d;
  logic [XLEN-1:0] csr_wd_q, csr_wd_d;
  logic            jump_flag_q, jump_flag_d;
  logic [XLEN-1:0] jump_addr_q, jump_addr_d;

  // Only the mie bits that map onto irq lines matter.
  logic unused_mie_bits;
  assign unused_mie_bits = ^csr_mie;

  // ---------------------------------------------------------------- decode
  logic             is_ecall, is_ebreak, is_mret;
  logic             irq_valid, irq_req;
  logic [IDX_W-1:0] irq_idx;
  logic [XLEN-1:0]  irq_code;
  logic [XLEN-1:0]  mtvec_base;
  logic             in_idle, take_sync, take_mret, take_irq;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio (
    .req_i   (irq),
    .mask_i  (csr_mie[IRQ_CAUSE_BASE +: NUM_IRQ]),
    .valid_o (irq_valid),
    .idx_o   (irq_idx)
  );

  assign is_ecall   = (inst == INST_ECALL);
  assign is_ebreak  = (inst == INST_EBREAK);
  assign is_mret    = (inst == INST_MRET);
  assign irq_req    = irq_valid & csr_mstatus[MSTATUS_MIE];
  assign irq_code   = XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_idx);
  assign mtvec_base = {csr_mtvec[XLEN-1:2], 2'b00};

  assign in_idle   = (state_q == IDLE);
  assign take_sync = in_idle & (is_ecall | is_ebreak);
  assign take_mret = in_idle & ~(is_ecall | is_ebreak) & is_mret;
  assign take_irq  = in_idle & ~(is_ecall | is_ebreak | is_mret) & irq_req;

  assign stall_flag  = ~in_idle | take_sync | take_mret | take_irq;
  assign trap_active = ~in_idle;

  // ------------------------------------------- values captured on detection
  always_comb begin
    cause_d  = cause_q;
    ret_pc_d = ret_pc_q;
    target_d = target_q;
    if (take_sync) begin
      cause_d  = is_ecall ? XLEN'(CAUSE_ECALL_M) : XLEN'(CAUSE_BREAKPOINT);
      ret_pc_d = inst_addr;
      target_d = mtvec_base;
    end else if (take_mret) begin
      target_d = csr_mepc;
    end else if (take_irq) begin
      cause_d  = {1'b1, irq_code[XLEN-2:0]};
      ret_pc_d = jump_flag_ex ? jump_addr_ex : inst_addr;
      // Vectored mode only offsets interrupts; exceptions use the base.
      if (VECTORED_EN && csr_mtvec[1:0] == 2'b01)
        target_d = mtvec_base + (irq_code << 2);
      else
        target_d = mtvec_base;
    end
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cause_q     <= '0;
      ret_pc_q    <= '0;
      target_q    <= '0;
      csr_we_q    <= 1'b0;
      csr_wa_q    <= '0;
      csr_wd_q    <= '0;
      jump_flag_q <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      ret_pc_q    <= ret_pc_d;
      target_q    <= target_d;
      csr_we_q    <= csr_we_d;
      csr_wa_q    <= csr_wa_d;
      csr_wd_q    <= csr_wd_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_sync || take_irq) state_d = WR_MEPC;
        else if (take_mret)        state_d = MRET_STATUS;
      end
      WR_MEPC:     state_d = WR_MCAUSE;
      WR_MCAUSE:   state_d = WR_MSTATUS;
      WR_MSTATUS:  state_d = JUMP;
      MRET_STATUS: state_d = JUMP;
      JUMP:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Outputs are registered from state_d so each value is present during the
  // cycle its state is occupied.
  logic [XLEN-1:0] mstatus_entry, mstatus_exit;

  always_comb begin
    mstatus_entry               = csr_mstatus;
    mstatus_entry[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
    mstatus_entry[MSTATUS_MIE]  = 1'b0;
    mstatus_exit                = csr_mstatus;
    mstatus_exit[MSTATUS_MIE]   = csr_mstatus[MSTATUS_MPIE];
    mstatus_exit[MSTATUS_MPIE]  = 1'b1;
  end

  always_comb begin
    csr_we_d    = 1'b0;
    csr_wa_d    = '0;
    csr_wd_d    = '0;
    jump_flag_d = 1'b0;
    jump_addr_d = '0;
    case (state_d)
      WR_MEPC: begin
        csr_we_d = 1'b1;
        csr_wa_d = CSR_MEPC;
        csr_wd_d = ret_pc_d;
      end
      WR_MCAUSE: begin
        csr_we_d = 1'b1;
        csr_wa_d = CSR_MCAUSE;
        csr_wd_d = cause_d;
      end
      WR_MSTATUS: begin
        csr_we_d = 1'b1;
        csr_wa_d = CSR_MSTATUS;
        csr_wd_d = mstatus_entry;
      end
      MRET_STATUS: begin
        csr_we_d = 1'b1;
        csr_wa_d = CSR_MSTATUS;
        csr_wd_d = mstatus_exit;
      end
      JUMP: begin
        jump_flag_d = 1'b1;
        jump_addr_d = target_d;
      end
      default: ;
    endcase
  end

  assign csr_we    = csr_we_q;
  assign csr_wa    = csr_wa_q;
  assign csr_wd    = csr_wd_q;
  assign jump_flag = jump_flag_q;
  assign jump_addr = jump_addr_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed test of trap_ctrl. A small CSR file in the stimulus
// applies the DUT's writes back to mstatus/mepc; an event-level model checks
// every cycle and directed literal checks pin the model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic [31:0] inst, inst_addr;
  logic        jump_flag_ex;
  logic [31:0] jump_addr_ex;
  logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
  logic        csr_we;
  logic [11:0] csr_wa;
  logic [31:0] csr_wd;
  logic        stall_flag, jump_flag, trap_active;
  logic [31:0] jump_addr;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  int n_pass = 0;
  int n_total = 0;

  trap_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .inst         (inst),
    .inst_addr    (inst_addr),
    .jump_flag_ex (jump_flag_ex),
    .jump_addr_ex (jump_addr_ex),
    .csr_mstatus  (csr_mstatus),
    .csr_mie      (csr_mie),
    .csr_mtvec    (csr_mtvec),
    .csr_mepc     (csr_mepc),
    .csr_we       (csr_we),
    .csr_wa       (csr_wa),
    .csr_wd       (csr_wd),
    .stall_flag   (stall_flag),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .trap_active  (trap_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        jf;
    logic [31:0] ja;
  } exp_t;

  exp_t        expq[$];
  exp_t        m_e;
  bit          m_hit, m_irq, m_sync, m_mret, m_ev;
  int          m_code;
  logic [31:0] m_base, m_tgt, m_ret, m_ms;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      chk("rst_we", csr_we, 0);
      chk("rst_wa", csr_wa, 0);
      chk("rst_wd", csr_wd, 0);
      chk("rst_jf", jump_flag, 0);
      chk("rst_ja", jump_addr, 0);
      chk("rst_active", trap_active, 0);
    end else if (expq.size() > 0) begin
      m_e = expq.pop_front();
      chk("seq_stall", stall_flag, 1);
      chk("seq_active", trap_active, 1);
      chk("seq_we", csr_we, m_e.we);
      if (m_e.we) begin
        chk("seq_wa", csr_wa, m_e.wa);
        chk("seq_wd", csr_wd, m_e.wd);
      end
      chk("seq_jf", jump_flag, m_e.jf);
      if (m_e.jf) chk("seq_ja", jump_addr, m_e.ja);
    end else begin
      m_hit = 0;
      m_code = 0;
      for (int i = 0; i < 4; i++) begin
        if (!m_hit && irq[i] && csr_mie[16+i]) begin
          m_hit = 1;
          m_code = 16 + i;
        end
      end
      m_sync = (inst == ECALL) || (inst == EBREAK);
      m_mret = (inst == MRET);
      m_irq  = m_hit && csr_mstatus[3];
      m_ev   = m_sync || m_mret || m_irq;
      chk("idle_stall", stall_flag, m_ev);
      chk("idle_we", csr_we, 0);
      chk("idle_jf", jump_flag, 0);
      chk("idle_active", trap_active, 0);
      m_base = csr_mtvec & ~32'h3;
      m_ms = csr_mstatus & ~32'h88;
      if (m_sync) begin
        expq.push_back('{1'b1, 12'h341, inst_addr, 1'b0, 32'h0});
        expq.push_back('{1'b1, 12'h342, (inst == ECALL) ? 32'd11 : 32'd3, 1'b0, 32'h0});
        expq.push_back('{1'b1, 12'h300, m_ms | (csr_mstatus[3] ? 32'h80 : 32'h0), 1'b0, 32'h0});
        expq.push_back('{1'b0, 12'h0, 32'h0, 1'b1, m_base});
      end else if (m_mret) begin
        expq.push_back('{1'b1, 12'h300, m_ms | 32'h80 | (csr_mstatus[7] ? 32'h8 : 32'h0), 1'b0, 32'h0});
        expq.push_back('{1'b0, 12'h0, 32'h0, 1'b1, csr_mepc});
      end else if (m_irq) begin
        m_ret = jump_flag_ex ? jump_addr_ex : inst_addr;
        m_tgt = (csr_mtvec[1:0] == 2'b01) ? m_base + 32'(4 * m_code) : m_base;
        expq.push_back('{1'b1, 12'h341, m_ret, 1'b0, 32'h0});
        expq.push_back('{1'b1, 12'h342, 32'h8000_0000 | 32'(m_code), 1'b0, 32'h0});
        expq.push_back('{1'b1, 12'h300, m_ms | (csr_mstatus[3] ? 32'h80 : 32'h0), 1'b0, 32'h0});
        expq.push_back('{1'b0, 12'h0, 32'h0, 1'b1, m_tgt});
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  // Advance one clock; the CSR write pending during the finished cycle is
  // committed to the bench's CSR copies, as a CSR file would at that edge.
  task automatic cyc();
    logic        pw;
    logic [11:0] pa;
    logic [31:0] pd;
    pw = csr_we;
    pa = csr_wa;
    pd = csr_wd;
    @(posedge clk);
    #1;
    if (pw) begin
      case (pa)
        12'h300: csr_mstatus = pd;
        12'h341: csr_mepc = pd;
        default: ;
      endcase
    end
  endtask

  // Called in the detection cycle; ends in the IDLE cycle after JUMP.
  task automatic trap_lits(input string nm, input logic [31:0] mepc, input logic [31:0] cause,
                           input logic [31:0] ms, input logic [31:0] ja);
    #1;
    chk({nm, "_stall"}, stall_flag, 1);
    cyc();
    inst = NOP;
    chk({nm, "_mepc_we"}, csr_we, 1);
    chk({nm, "_mepc_wa"}, csr_wa, 12'h341);
    chk({nm, "_mepc_wd"}, csr_wd, mepc);
    cyc();
    chk({nm, "_mcause_wa"}, csr_wa, 12'h342);
    chk({nm, "_mcause_wd"}, csr_wd, cause);
    cyc();
    chk({nm, "_mstatus_wa"}, csr_wa, 12'h300);
    chk({nm, "_mstatus_wd"}, csr_wd, ms);
    cyc();
    chk({nm, "_jump_we"}, csr_we, 0);
    chk({nm, "_jump_jf"}, jump_flag, 1);
    chk({nm, "_jump_ja"}, jump_addr, ja);
    cyc();
    chk({nm, "_after_jf"}, jump_flag, 0);
  endtask

  task automatic mret_lits(input string nm, input logic [31:0] ms, input logic [31:0] ja);
    #1;
    chk({nm, "_stall"}, stall_flag, 1);
    cyc();
    inst = NOP;
    chk({nm, "_status_we"}, csr_we, 1);
    chk({nm, "_status_wa"}, csr_wa, 12'h300);
    chk({nm, "_status_wd"}, csr_wd, ms);
    cyc();
    chk({nm, "_jump_jf"}, jump_flag, 1);
    chk({nm, "_jump_ja"}, jump_addr, ja);
    cyc();
    chk({nm, "_after_jf"}, jump_flag, 0);
  endtask

  task automatic quiet(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({nm, "_stall"}, stall_flag, 0);
      chk({nm, "_active"}, trap_active, 0);
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    irq = '0;
    inst = NOP;
    inst_addr = '0;
    jump_flag_ex = 1'b0;
    jump_addr_ex = '0;
    csr_mstatus = '0;
    csr_mie = '0;
    csr_mtvec = '0;
    csr_mepc = '0;
    #2;
    chk("reset_active", trap_active, 0);
    chk("reset_jf", jump_flag, 0);
    chk("reset_we", csr_we, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();

    // ecall, direct mtvec
    csr_mstatus = 32'h8; csr_mtvec = 32'h800; inst_addr = 32'h100; inst = ECALL;
    trap_lits("ecall", 32'h100, 32'd11, 32'h80, 32'h800);
    $display("txn ecall done");

    // ebreak with vectored mtvec: exceptions still use the base
    csr_mstatus = 32'h8; csr_mtvec = 32'h801; inst_addr = 32'h200; inst = EBREAK;
    trap_lits("ebreak", 32'h200, 32'd3, 32'h80, 32'h800);
    $display("txn ebreak done");

    // irq[2], vectored
    csr_mstatus = 32'h8; csr_mtvec = 32'h801; csr_mie = 32'h1 << 18; inst_addr = 32'h300; irq = 4'b0100;
    trap_lits("irq2_vec", 32'h300, 32'h8000_0012, 32'h80, 32'h848);
    quiet("irq2_mie_off", 3);
    irq = '0;
    $display("txn irq2 vectored done");

    // irq[2] while EX redirects: return PC is the EX target
    csr_mstatus = 32'h8; csr_mtvec = 32'h800; inst_addr = 32'h310;
    jump_flag_ex = 1'b1; jump_addr_ex = 32'h240; irq = 4'b0100;
    trap_lits("irq2_ex", 32'h240, 32'h8000_0012, 32'h80, 32'h800);
    jump_flag_ex = 1'b0; irq = '0;
    $display("txn irq2 ex-redirect done");

    // irq[1] and irq[3] together: lowest index wins
    csr_mstatus = 32'h8; csr_mie = 32'hF << 16; inst_addr = 32'h320; irq = 4'b1010;
    trap_lits("irq13", 32'h320, 32'h8000_0011, 32'h80, 32'h800);
    irq = '0;
    $display("txn irq1+irq3 done");

    // irq[0] masked off in mie, irq[3] enabled, vectored
    csr_mstatus = 32'h8; csr_mie = 32'hE << 16; csr_mtvec = 32'h801; inst_addr = 32'h330; irq = 4'b1001;
    trap_lits("irq3_mask", 32'h330, 32'h8000_0013, 32'h80, 32'h84C);
    irq = '0; csr_mtvec = 32'h800;
    $display("txn masked irq0 done");

    // MIE clear: pending irq is not taken
    csr_mstatus = 32'h0; csr_mie = 32'hF << 16; irq = 4'b0100;
    quiet("mie0", 3);
    irq = '0;
    $display("txn mie=0 done");

    // mret
    csr_mstatus = 32'h80; csr_mepc = 32'h104; inst = MRET;
    mret_lits("mret", 32'h88, 32'h104);
    $display("txn mret done");

    // mret with irq[1] pending: mret first, irq taken after MIE restored
    csr_mstatus = 32'h88; csr_mepc = 32'h108; inst_addr = 32'h400; irq = 4'b0010; inst = MRET;
    mret_lits("mret_irq", 32'h88, 32'h108);
    trap_lits("retake_irq1", 32'h400, 32'h8000_0011, 32'h80, 32'h800);
    irq = '0;
    $display("txn mret+irq done");

    // ecall with irq[0] at the same time: ecall wins, no second trap
    csr_mstatus = 32'h8; csr_mie = 32'hF << 16; inst_addr = 32'h500; irq = 4'b0001; inst = ECALL;
    trap_lits("ecall_irq", 32'h500, 32'd11, 32'h80, 32'h800);
    quiet("ecall_irq_no2nd", 4);
    irq = '0;
    $display("txn ecall+irq done");

    // reset during WR_MCAUSE
    csr_mstatus = 32'h8; inst_addr = 32'h600; inst = ECALL;
    #1;
    cyc();
    inst = NOP;
    cyc();
    chk("midrst_pre_wa", csr_wa, 12'h342);
    rst = 1'b1;
    #1;
    chk("midrst_we", csr_we, 0);
    chk("midrst_wa", csr_wa, 0);
    chk("midrst_wd", csr_wd, 0);
    chk("midrst_jf", jump_flag, 0);
    chk("midrst_ja", jump_addr, 0);
    chk("midrst_active", trap_active, 0);
    chk("midrst_stall", stall_flag, 0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("midrst_nojump", jump_flag, 0);
      cyc();
    end
    $display("txn reset mid-sequence done");

    cyc();
    chk("model_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
